iob_responder: RTL and testbench

- Synchronous 68000-bus slave (responder) for the PDS/IOB side; the other end of the cycles the IOB bus master drives.
- Decodes nAS/nUDS/nLDS/nWE/A_IOB against a card window and answers with nDTACK after programmable wait states, or with nVPA followed by an E-clock-synchronous (VMA) transfer.
- Backs a 4 x 16-bit register file.
- Used as the on-card register target and as the bus-master bench partner.

---
 rtl/iob_responder_if.sv | 36 +++
 rtl/iob_responder.sv | 226 ++++++++++++++++++++++
 tb/tb_iob_responder.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iob_responder_if.sv
// iob_responder_if -- 68000-style IOB bus bundle between a bus master and the responder.
//
// Signals:
//   A_IOB[23:1]           address
//   D_IOB_in / D_IOB_out  write data from the master, read data from the responder
//   nDoe                  active-low enable for the responder's read-data driver
//   nAS/nUDS/nLDS/nWE     master strobes, already synchronous to CLK_IOB
//   nVMA_IOB, E_IOB       valid memory address and the sampled E clock
//   nDTACK/nVPA/nBERR     responder replies, active low, 1 = released
//
// Modports: master (bus master / bench side) and slave (responder side).
interface iob_responder_if;
   logic [23:1] A_IOB;
   logic [15:0] D_IOB_in;
   logic [15:0] D_IOB_out;
   logic        nDoe;
   logic        nAS_IOB;
   logic        nUDS_IOB;
   logic        nLDS_IOB;
   logic        nWE_IOB;
   logic        nVMA_IOB;
   logic        E_IOB;
   logic        nDTACK_IOB;
   logic        nVPA_IOB;
   logic        nBERR_IOB;

   modport master (
      output A_IOB, D_IOB_in, nAS_IOB, nUDS_IOB, nLDS_IOB, nWE_IOB, nVMA_IOB, E_IOB,
      input  D_IOB_out, nDoe, nDTACK_IOB, nVPA_IOB, nBERR_IOB
   );

   modport slave (
      input  A_IOB, D_IOB_in, nAS_IOB, nUDS_IOB, nLDS_IOB, nWE_IOB, nVMA_IOB, E_IOB,
      output D_IOB_out, nDoe, nDTACK_IOB, nVPA_IOB, nBERR_IOB
   );
endinterface

// File: rtl/iob_responder.sv
// iob_responder -- synchronous 68000-bus slave backing a 4 x 16-bit register file.
//
// A cycle hits when nAS is low, at least one data strobe is low and A_IOB[23:16] == BASE.
// A_IOB[15] = 0 answers with nDTACK after WAIT_STATES cycles; A_IOB[15] = 1 answers with
// nVPA and completes an E-clock synchronous (VMA) transfer on the next E falling edge.
// A_IOB[2:1] selects the register; A_IOB[14:3] are ignored so the registers alias.
//
// Ports:
//   CLK_IOB    sole clock, rising edge
//   RESET_IOB  synchronous active-high reset
//   bus        iob_responder_if.slave bundle (address, data, strobes, replies)
//
// Optional feature macro IOB_BERR_EN: a watchdog in the VPA/VMA states asserts nBERR after
// TIMEOUT cycles without completion and suppresses the write. Without it nBERR is tied high.
module iob_responder #(
   parameter logic [7:0]  BASE        = 8'hF8,
   parameter int unsigned WAIT_STATES = 2,
   parameter int unsigned TIMEOUT     = 64
) (
   input logic           CLK_IOB,
   input logic           RESET_IOB,
   iob_responder_if.slave bus
);

   typedef enum logic [2:0] {
      StIdle,
      StWait,
      StAck,
      StVpa,
      StVma,
      StRelease,
      StBerr
   } state_t;

   state_t      state;
   logic [3:0]  wait_cnt;
   logic [1:0]  sel;
   logic        wr;
   logic        e_prev;
   logic        dtack_n;
   logic        vpa_n;
   logic        doe_n;
   logic [15:0] dout;
   logic [15:0] regs [4];
   logic        hit;
   logic        unused_addr;

   assign hit = !bus.nAS_IOB && (!bus.nUDS_IOB || !bus.nLDS_IOB) &&
                (bus.A_IOB[23:16] == BASE);

   // Middle address bits only alias the register file.
   assign unused_addr = ^bus.A_IOB[14:3];

   // Byte lanes are independent: nUDS gates [15:8], nLDS gates [7:0].
   function automatic logic [15:0] lane_merge(input logic [15:0] old, input logic [15:0] wdata,
                                              input logic uds_n, input logic lds_n);
      lane_merge = old;
      if (!uds_n) lane_merge[15:8] = wdata[15:8];
      if (!lds_n) lane_merge[7:0] = wdata[7:0];
   endfunction

`ifdef IOB_BERR_EN
   logic        berr_n;
   logic [15:0] wd_cnt;
   logic        wd_expired;

   assign wd_expired = (wd_cnt == 16'(TIMEOUT - 1));
   assign bus.nBERR_IOB = berr_n;
`else
   logic [15:0] unused_timeout;

   assign unused_timeout = 16'(TIMEOUT);
   assign bus.nBERR_IOB = 1'b1;
`endif

   always_ff @(posedge CLK_IOB) begin
      if (RESET_IOB) begin
         state    <= StIdle;
         wait_cnt <= '0;
         sel      <= '0;
         wr       <= 1'b0;
         e_prev   <= 1'b0;
         dtack_n  <= 1'b1;
         vpa_n    <= 1'b1;
         doe_n    <= 1'b1;
         dout     <= '0;
         for (int i = 0; i < 4; i++) regs[i] <= '0;
`ifdef IOB_BERR_EN
         berr_n   <= 1'b1;
         wd_cnt   <= '0;
`endif
      end else begin
         e_prev <= bus.E_IOB;
         case (state)
            StIdle: begin
               dtack_n <= 1'b1;
               vpa_n   <= 1'b1;
               doe_n   <= 1'b1;
               dout    <= '0;
`ifdef IOB_BERR_EN
               berr_n  <= 1'b1;
               wd_cnt  <= '0;
`endif
               if (hit) begin
                  sel <= bus.A_IOB[2:1];
                  wr  <= !bus.nWE_IOB;
                  if (bus.A_IOB[15]) begin
                     state <= StVpa;
                  end else begin
                     state    <= StWait;
                     wait_cnt <= 4'(WAIT_STATES);
                  end
               end
            end

            StWait: begin
               if (bus.nAS_IOB) begin
                  state <= StIdle;
               end else if (wait_cnt == 4'd0) begin
                  // Acknowledge, read data and write all take effect on ACK entry.
                  state   <= StAck;
                  dtack_n <= 1'b0;
                  if (wr) begin
                     regs[sel] <= lane_merge(regs[sel], bus.D_IOB_in, bus.nUDS_IOB,
                                             bus.nLDS_IOB);
                  end else begin
                     doe_n <= 1'b0;
                     dout  <= regs[sel];
                  end
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end

            StAck: begin
               state <= StRelease;
            end

            StVpa: begin
               if (bus.nAS_IOB) begin
                  state <= StIdle;
                  vpa_n <= 1'b1;
               end else begin
                  vpa_n <= 1'b0;
                  if (!bus.nVMA_IOB && bus.E_IOB) begin
                     // VMA during E high: the transfer completes on this E's falling edge.
                     state <= StVma;
                     if (!wr) begin
                        doe_n <= 1'b0;
                        dout  <= regs[sel];
                     end
                  end
`ifdef IOB_BERR_EN
                  else if (wd_expired) begin
                     state  <= StBerr;
                     berr_n <= 1'b0;
                     vpa_n  <= 1'b1;
                  end else begin
                     wd_cnt <= wd_cnt + 16'd1;
                  end
`endif
               end
            end

            StVma: begin
               if (bus.nAS_IOB) begin
                  state <= StIdle;
                  vpa_n <= 1'b1;
                  doe_n <= 1'b1;
                  dout  <= '0;
               end else if (e_prev && !bus.E_IOB) begin
                  state <= StRelease;
                  if (wr) begin
                     regs[sel] <= lane_merge(regs[sel], bus.D_IOB_in, bus.nUDS_IOB,
                                             bus.nLDS_IOB);
                  end
               end
`ifdef IOB_BERR_EN
               else if (wd_expired) begin
                  state  <= StBerr;
                  berr_n <= 1'b0;
                  vpa_n  <= 1'b1;
                  doe_n  <= 1'b1;
                  dout   <= '0;
               end else begin
                  wd_cnt <= wd_cnt + 16'd1;
               end
`endif
            end

            StRelease: begin
               if (bus.nAS_IOB) begin
                  state   <= StIdle;
                  dtack_n <= 1'b1;
                  vpa_n   <= 1'b1;
                  doe_n   <= 1'b1;
                  dout    <= '0;
               end else if (bus.nUDS_IOB && bus.nLDS_IOB) begin
                  // Data driver may drop as soon as both strobes rise.
                  doe_n <= 1'b1;
                  dout  <= '0;
               end
            end

            StBerr: begin
               if (bus.nAS_IOB) begin
                  state <= StIdle;
`ifdef IOB_BERR_EN
                  berr_n <= 1'b1;
`endif
               end
            end

            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

   assign bus.nDTACK_IOB = dtack_n;
   assign bus.nVPA_IOB   = vpa_n;
   assign bus.nDoe       = doe_n;
   assign bus.D_IOB_out  = dout;

endmodule

// File: tb/tb_iob_responder.sv
// tb_iob_responder -- self-checking bench for iob_responder.
// Table of DTACK-path transactions, hand sequences for VPA, abort and reset corner cases,
// then randomized DTACK-path traffic checked against a word/lane register model.
// With IOB_BERR_EN defined the watchdog sequence is exercised as well.
module tb_iob_responder;
   localparam int unsigned WS  = 2;
   localparam int unsigned TMO = 64;

   logic CLK_IOB = 1'b0;
   logic RESET_IOB = 1'b1;
   iob_responder_if bus ();

   iob_responder #(
      .BASE        (8'hF8),
      .WAIT_STATES (WS),
      .TIMEOUT     (TMO)
   ) dut (
      .CLK_IOB   (CLK_IOB),
      .RESET_IOB (RESET_IOB),
      .bus       (bus)
   );

   always #5 CLK_IOB = ~CLK_IOB;

   int vectors = 0;
   int miscompares = 0;
   logic [15:0] model [4];

   typedef struct {
      logic [23:0] addr;
      logic [15:0] data;
      logic        we_n;
      logic        uds_n;
      logic        lds_n;
      logic        hit;
      logic [15:0] exp_rd;
   } vec_t;

   vec_t tbl [12];

   task automatic tick();
      @(posedge CLK_IOB);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_write(input logic [1:0] r, input logic [15:0] d, input logic uds_n,
                              input logic lds_n);
      if (!uds_n) model[r] = (model[r] & 16'h00FF) | (d & 16'hFF00);
      if (!lds_n) model[r] = (model[r] & 16'hFF00) | (d & 16'h00FF);
   endtask

   task automatic bus_idle();
      bus.nAS_IOB  = 1'b1;
      bus.nUDS_IOB = 1'b1;
      bus.nLDS_IOB = 1'b1;
      bus.nWE_IOB  = 1'b1;
      bus.nVMA_IOB = 1'b1;
      bus.E_IOB    = 1'b0;
   endtask

   // One DTACK-style cycle; lat counts edges with AS low, the sampling edge being 1.
   task automatic bus_cycle(input logic [23:0] addr, input logic [15:0] data,
                            input logic we_n, input logic uds_n, input logic lds_n,
                            output int lat, output logic [15:0] rd, output logic doe_n_seen,
                            output logic other_seen, output logic released);
      bus.A_IOB    = addr[23:1];
      bus.D_IOB_in = data;
      bus.nWE_IOB  = we_n;
      bus.nUDS_IOB = uds_n;
      bus.nLDS_IOB = lds_n;
      bus.nAS_IOB  = 1'b0;
      lat = 0;
      rd = '0;
      doe_n_seen = 1'b1;
      other_seen = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (!bus.nVPA_IOB || !bus.nBERR_IOB || (!bus.nDoe && bus.nDTACK_IOB)) other_seen = 1'b1;
         if (!bus.nDTACK_IOB) begin
            lat = i;
            rd = bus.D_IOB_out;
            doe_n_seen = bus.nDoe;
            break;
         end
      end
      bus_idle();
      tick();
      tick();
      released = bus.nDTACK_IOB && bus.nDoe && bus.nVPA_IOB && (bus.D_IOB_out == 16'h0);
      tick();
   endtask

   task automatic vpa_cycle(input logic [23:0] addr, input logic [15:0] data,
                            input logic we_n, input logic uds_n, input logic lds_n,
                            input int pre, output int lat, output logic [15:0] rd,
                            output logic doe_early, output logic doe_n_vma,
                            output logic vpa_held, output logic vpa_rel);
      bus.A_IOB    = addr[23:1];
      bus.D_IOB_in = data;
      bus.nWE_IOB  = we_n;
      bus.nUDS_IOB = uds_n;
      bus.nLDS_IOB = lds_n;
      bus.E_IOB    = 1'b0;
      bus.nVMA_IOB = 1'b1;
      bus.nAS_IOB  = 1'b0;
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (!bus.nVPA_IOB) begin
            lat = i;
            break;
         end
      end
      bus.nVMA_IOB = 1'b0;
      doe_early = 1'b0;
      for (int i = 0; i < pre; i++) begin
         tick();
         if (!bus.nDoe) doe_early = 1'b1;
      end
      bus.E_IOB = 1'b1;
      tick();
      doe_n_vma = bus.nDoe;
      rd = bus.D_IOB_out;
      bus.E_IOB = 1'b0;
      tick();
      vpa_held = !bus.nVPA_IOB;
      bus_idle();
      tick();
      vpa_rel = bus.nVPA_IOB && bus.nDoe;
      tick();
   endtask

   initial begin
      int lat;
      logic [15:0] rd;
      logic doe_n_seen, other, rel, doe_early, doe_vma, held;
      logic seen;

      tbl[0]  = '{24'hF80004, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
      tbl[1]  = '{24'hF80004, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'hBEEF};
      tbl[2]  = '{24'hF80002, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
      tbl[3]  = '{24'hF80002, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000};
      tbl[4]  = '{24'hF80002, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFF34};
      tbl[5]  = '{24'hF80002, 16'hAB00, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000};
      tbl[6]  = '{24'hF80002, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'hAB34};
      tbl[7]  = '{24'hF87FF2, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'hAB34};
      tbl[8]  = '{24'hF80006, 16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
      tbl[9]  = '{24'hF70000, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
      tbl[10] = '{24'hF70004, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
      tbl[11] = '{24'hF80000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000};

      for (int i = 0; i < 4; i++) model[i] = 16'h0;
      bus.A_IOB = '0;
      bus.D_IOB_in = '0;
      bus_idle();
      RESET_IOB = 1'b1;
      tick();
      tick();
      check("reset_dtack", {31'd0, bus.nDTACK_IOB}, 32'd1);
      check("reset_vpa", {31'd0, bus.nVPA_IOB}, 32'd1);
      check("reset_berr", {31'd0, bus.nBERR_IOB}, 32'd1);
      check("reset_doe", {31'd0, bus.nDoe}, 32'd1);
      check("reset_dout", {16'd0, bus.D_IOB_out}, 32'd0);
      RESET_IOB = 1'b0;
      tick();

      for (int i = 0; i < 12; i++) begin
         bus_cycle(tbl[i].addr, tbl[i].data, tbl[i].we_n, tbl[i].uds_n, tbl[i].lds_n,
                   lat, rd, doe_n_seen, other, rel);
         check($sformatf("tbl%0d_lat", i), lat, tbl[i].hit ? WS + 2 : 0);
         check($sformatf("tbl%0d_other", i), {31'd0, other}, 32'd0);
         check($sformatf("tbl%0d_release", i), {31'd0, rel}, 32'd1);
         if (tbl[i].hit && tbl[i].we_n) begin
            check($sformatf("tbl%0d_rdata", i), {16'd0, rd}, {16'd0, tbl[i].exp_rd});
            check($sformatf("tbl%0d_doe", i), {31'd0, doe_n_seen}, 32'd0);
         end
         if (tbl[i].hit && !tbl[i].we_n)
            model_write(tbl[i].addr[2:1], tbl[i].data, tbl[i].uds_n, tbl[i].lds_n);
      end

      // Abort in WAIT: write to R0 dropped, no acknowledge.
      bus.A_IOB = 23'(24'hF80000 >> 1);
      bus.D_IOB_in = 16'h1111;
      bus.nWE_IOB = 1'b0;
      bus.nUDS_IOB = 1'b0;
      bus.nLDS_IOB = 1'b0;
      bus.nAS_IOB = 1'b0;
      tick();
      bus_idle();
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (!bus.nDTACK_IOB) seen = 1'b1;
      end
      check("abort_no_dtack", {31'd0, seen}, 32'd0);
      bus_cycle(24'hF80000, 16'h0, 1'b1, 1'b0, 1'b0, lat, rd, doe_n_seen, other, rel);
      check("abort_r0", {16'd0, rd}, 32'd0);

      // VPA read of R3, VMA raised while E already high.
      vpa_cycle(24'hF88006, 16'h0, 1'b1, 1'b0, 1'b0, 0, lat, rd, doe_early, doe_vma, held, rel);
      check("vpa_lat", lat, 2);
      check("vpa_rdata", {16'd0, rd}, 32'h5A5A);
      check("vpa_doe", {31'd0, doe_vma}, 32'd0);
      check("vpa_held", {31'd0, held}, 32'd1);
      check("vpa_release", {31'd0, rel}, 32'd1);

      // VPA write of R0, VMA low through several E-low cycles first.
      vpa_cycle(24'hF88000, 16'hC3C3, 1'b0, 1'b0, 1'b0, 3, lat, rd, doe_early, doe_vma, held,
                rel);
      model_write(2'd0, 16'hC3C3, 1'b0, 1'b0);
      check("vpaw_lat", lat, 2);
      check("vpaw_doe", {31'd0, doe_early | ~doe_vma}, 32'd0);
      check("vpaw_release", {31'd0, rel}, 32'd1);
      bus_cycle(24'hF80000, 16'h0, 1'b1, 1'b0, 1'b0, lat, rd, doe_n_seen, other, rel);
      check("vpaw_readback", {16'd0, rd}, {16'd0, model[0]});

      // Reset pulsed while nDTACK is asserted.
      bus.A_IOB = 23'(24'hF80002 >> 1);
      bus.D_IOB_in = 16'h7777;
      bus.nWE_IOB = 1'b0;
      bus.nUDS_IOB = 1'b0;
      bus.nLDS_IOB = 1'b0;
      bus.nAS_IOB = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (!bus.nDTACK_IOB) begin
            seen = 1'b1;
            break;
         end
      end
      check("rst_dtack_seen", {31'd0, seen}, 32'd1);
      RESET_IOB = 1'b1;
      bus_idle();
      tick();
      check("rst_mid_dtack", {31'd0, bus.nDTACK_IOB}, 32'd1);
      check("rst_mid_doe", {31'd0, bus.nDoe}, 32'd1);
      check("rst_mid_vpa", {31'd0, bus.nVPA_IOB}, 32'd1);
      RESET_IOB = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) model[i] = 16'h0;
      for (int r = 0; r < 4; r++) begin
         bus_cycle({8'hF8, 13'd0, 2'(r), 1'b0}, 16'h0, 1'b1, 1'b0, 1'b0, lat, rd, doe_n_seen,
                   other, rel);
         check($sformatf("rst_r%0d", r), {16'd0, rd}, 32'd0);
      end

`ifdef IOB_BERR_EN
      // Watchdog: VPA write with nVMA never asserted.
      bus.A_IOB = 23'(24'hF88004 >> 1);
      bus.D_IOB_in = 16'h9999;
      bus.nWE_IOB = 1'b0;
      bus.nUDS_IOB = 1'b0;
      bus.nLDS_IOB = 1'b0;
      bus.nAS_IOB = 1'b0;
      lat = 0;
      for (int i = 1; i <= int'(TMO) + 10; i++) begin
         tick();
         if (!bus.nBERR_IOB) begin
            lat = i;
            break;
         end
      end
      check("berr_window", {31'd0, (lat >= int'(TMO)) && (lat <= int'(TMO) + 1)}, 32'd1);
      tick();
      check("berr_held", {31'd0, bus.nBERR_IOB}, 32'd0);
      bus_idle();
      tick();
      tick();
      check("berr_release", {31'd0, bus.nBERR_IOB}, 32'd1);
      bus_cycle(24'hF80004, 16'h0, 1'b1, 1'b0, 1'b0, lat, rd, doe_n_seen, other, rel);
      check("berr_nowrite", {16'd0, rd}, {16'd0, model[2]});
`endif

      // Randomized DTACK-path traffic against the register model.
      for (int n = 0; n < 60; n++) begin
         logic [23:0] a;
         logic [7:0] top;
         logic [1:0] lanes;
         logic [15:0] d;
         logic we_n, hit;
         hit = ($urandom_range(0, 5) != 0);
         top = 8'($urandom_range(0, 255));
         if (top == 8'hF8) top = 8'hF7;
         a = {hit ? 8'hF8 : top, 1'b0, 12'($urandom), 2'($urandom), 1'b0};
         lanes = 2'($urandom_range(1, 3));
         d = 16'($urandom);
         we_n = 1'($urandom);
         bus_cycle(a, d, we_n, ~lanes[1], ~lanes[0], lat, rd, doe_n_seen, other, rel);
         check($sformatf("rnd%0d_lat", n), lat, hit ? WS + 2 : 0);
         check($sformatf("rnd%0d_release", n), {31'd0, rel & ~other}, 32'd1);
         if (hit && we_n)
            check($sformatf("rnd%0d_rdata", n), {16'd0, rd}, {16'd0, model[a[2:1]]});
         if (hit && !we_n) model_write(a[2:1], d, ~lanes[1], ~lanes[0]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
